// File: rtl/sequence_player_if.sv
// Control, pattern and status signals of sequence_player.
// The master side issues play requests; the slave side is the player itself.
interface sequence_player_if #(
  parameter int SEQ_LEN = 18,
  parameter int DIV_W   = 28
);
  localparam int IDX_W = $clog2(SEQ_LEN + 1);

  logic [SEQ_LEN-1:0] seq_in;
  logic [DIV_W-1:0]   period;
  logic               start;
  logic               abort;
  logic               msb_first;
  logic               loop;
  logic               blank;
  logic               out;
  logic [IDX_W-1:0]   index;
  logic               busy;
  logic               done;

  modport master (
    output seq_in, period, start, abort, msb_first, loop, blank,
    input  out, index, busy, done
  );

  modport slave (
    input  seq_in, period, start, abort, msb_first, loop, blank,
    output out, index, busy, done
  );
endinterface

// File: rtl/sequence_player.sv
// Serial sequence player: latches a pattern on start and shifts it out one bit
// per slot, each slot lasting period+1 clocks, with optional gap slots,
// LSB/MSB-first order, looping, and a busy/done/abort handshake.
module sequence_player #(
  parameter int SEQ_LEN = 18,
  parameter int DIV_W   = 28
) (
  input  logic              clock,
  input  logic              resetn,
  sequence_player_if.slave  bus
);
  localparam int IDX_W = $clog2(SEQ_LEN + 1);
  // All-ones index marks a gap slot; it can never equal a bit ordinal.
  localparam logic [IDX_W-1:0] GAP_IDX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t             state_q, state_d;
  logic [SEQ_LEN-1:0] shift_q, shift_d;
  logic [SEQ_LEN-1:0] copy_q,  copy_d;
  logic [IDX_W-1:0]   cnt_q,   cnt_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [DIV_W-1:0]   q_q,     q_d;
  logic               msb_q,   msb_d;
  logic               loop_q,  loop_d;
  logic               blank_q, blank_d;
  logic               out_q,   out_d;
  logic               done_q,  done_d;

  logic               tick;
  logic [SEQ_LEN-1:0] shifted;

  // Bit that leads a pattern in the given playback order.
  function automatic logic first_bit(input logic [SEQ_LEN-1:0] v, input logic msb);
    return msb ? v[SEQ_LEN-1] : v[0];
  endfunction

  // Slot boundary: divider has run out while playing.
  assign tick = (state_q != IDLE) && (q_q == '0);

  // Working register moved one place so the next bit sits at the leading end.
  assign shifted = msb_q ? {shift_q[SEQ_LEN-2:0], 1'b0} : {1'b0, shift_q[SEQ_LEN-1:1]};

  assign bus.out   = out_q;
  assign bus.index = index_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;

  // Next-state and output logic; abort overrides everything.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d = state_q;
    shift_d = shift_q;
    copy_d  = copy_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    q_d     = q_q;
    msb_d   = msb_q;
    loop_d  = loop_q;
    blank_d = blank_q;
    out_d   = out_q;
    done_d  = 1'b0;

    if (bus.abort) begin
      state_d = IDLE;
      out_d   = 1'b0;
      index_d = '0;
      q_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            shift_d = bus.seq_in;
            copy_d  = bus.seq_in;
            msb_d   = bus.msb_first;
            loop_d  = bus.loop;
            blank_d = bus.blank;
            q_d     = bus.period;
            cnt_d   = '0;
            out_d   = first_bit(bus.seq_in, bus.msb_first);
            index_d = '0;
            state_d = SHOW;
          end
        end
        default: begin
          q_d = tick ? bus.period : q_q - 1'b1;
          if (tick) begin
            if (state_q == SHOW && blank_q) begin
              state_d = GAP;
              out_d   = 1'b1;
              index_d = GAP_IDX;
            end else if (cnt_q < LAST_IDX) begin
              shift_d = shifted;
              cnt_d   = cnt_q + 1'b1;
              out_d   = first_bit(shifted, msb_q);
              index_d = cnt_q + 1'b1;
              state_d = SHOW;
            end else if (loop_q) begin
              shift_d = copy_q;
              cnt_d   = '0;
              out_d   = first_bit(copy_q, msb_q);
              index_d = '0;
              state_d = SHOW;
            end else begin
              state_d = IDLE;
              out_d   = 1'b0;
              index_d = '0;
              done_d  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State and datapath registers; pattern storage is cleared on reset as well.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      shift_q <= '0;
      copy_q  <= '0;
      cnt_q   <= '0;
      index_q <= '0;
      q_q     <= '0;
      msb_q   <= 1'b0;
      loop_q  <= 1'b0;
      blank_q <= 1'b0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      shift_q <= shift_d;
      copy_q  <= copy_d;
      cnt_q   <= cnt_d;
      index_q <= index_d;
      q_q     <= q_d;
      msb_q   <= msb_d;
      loop_q  <= loop_d;
      blank_q <= blank_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player: a small SEQ_LEN=4 instance for the
// table of one-shot playbacks and corner cases, and a default-size instance.
module tb_sequence_player;
  logic clock = 1'b0;
  logic resetn;

  always #5 clock = ~clock;

  sequence_player_if #(.SEQ_LEN(4),  .DIV_W(8))  sb ();
  sequence_player_if #(.SEQ_LEN(18), .DIV_W(28)) bb ();

  sequence_player #(.SEQ_LEN(4),  .DIV_W(8))  dut_s (.clock(clock), .resetn(resetn), .bus(sb));
  sequence_player #(.SEQ_LEN(18), .DIV_W(28)) dut_b (.clock(clock), .resetn(resetn), .bus(bb));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic [3:0] seq;
    int         period;
    bit         msb;
    bit         blank;
    logic [7:0] exp_out;  // expected out per slot, slot 0 in bit 0
    int         nslots;
    int         hold;     // cycles to keep start high with junk inputs after acceptance
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Start a one-shot play on the small instance and check every cycle until done.
  task automatic run_play(input vec_t v);
    int s;
    logic [31:0] exp_idx;
    sb.seq_in = v.seq; sb.period = 8'(v.period); sb.msb_first = v.msb;
    sb.blank = v.blank; sb.loop = 1'b0; sb.start = 1'b1;
    step();
    sb.start = 1'b0;
    if (v.hold > 0) begin
      sb.start = 1'b1; sb.seq_in = ~v.seq; sb.msb_first = ~v.msb;
      sb.blank = ~v.blank; sb.loop = 1'b1;
    end
    for (int c = 0; c < v.nslots * (v.period + 1); c++) begin
      s = c / (v.period + 1);
      exp_idx = v.blank ? ((s % 2 == 1) ? 32'd7 : 32'(s / 2)) : 32'(s);
      check($sformatf("%s c%0d out", v.name, c), 32'(sb.out), 32'(v.exp_out[s]));
      check($sformatf("%s c%0d index", v.name, c), 32'(sb.index), exp_idx);
      check($sformatf("%s c%0d busy", v.name, c), 32'(sb.busy), 32'd1);
      check($sformatf("%s c%0d done", v.name, c), 32'(sb.done), 32'd0);
      if (c + 1 == v.hold) begin
        sb.start = 1'b0; sb.loop = 1'b0;
      end
      step();
    end
    check({v.name, " end busy"}, 32'(sb.busy), 32'd0);
    check({v.name, " end done"}, 32'(sb.done), 32'd1);
    check({v.name, " end out"}, 32'(sb.out), 32'd0);
    check({v.name, " end index"}, 32'(sb.index), 32'd0);
  endtask

  initial begin
    logic [3:0] lp;
    int max_idx;

    vecs[0] = '{"lsb_plain",  4'b1011, 2, 1'b0, 1'b0, 8'b0000_1011, 4, 0};
    vecs[1] = '{"msb_blank",  4'b1011, 2, 1'b1, 1'b1, 8'b1111_1011, 8, 0};
    vecs[2] = '{"msb_p0",     4'b0110, 0, 1'b1, 1'b0, 8'b0000_0110, 4, 0};
    vecs[3] = '{"lsb_blank",  4'b1100, 1, 1'b0, 1'b1, 8'b1111_1010, 8, 0};
    vecs[4] = '{"busy_start", 4'b1011, 1, 1'b0, 1'b0, 8'b0000_1011, 4, 4};

    sb.seq_in = '0; sb.period = '0; sb.start = 0; sb.abort = 0;
    sb.msb_first = 0; sb.loop = 0; sb.blank = 0;
    bb.seq_in = '0; bb.period = '0; bb.start = 0; bb.abort = 0;
    bb.msb_first = 0; bb.loop = 0; bb.blank = 0;

    // Reset state
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check("rst out", 32'(sb.out), 32'd0);
    check("rst index", 32'(sb.index), 32'd0);
    check("rst busy", 32'(sb.busy), 32'd0);
    check("rst done", 32'(sb.done), 32'd0);
    step(); step();
    resetn = 1'b1;
    step();
    check("idle busy", 32'(sb.busy), 32'd0);

    // Table of one-shot playbacks
    foreach (vecs[i]) begin
      run_play(vecs[i]);
      step();
      check({vecs[i].name, " done drop"}, 32'(sb.done), 32'd0);
      check({vecs[i].name, " stays idle"}, 32'(sb.busy), 32'd0);
    end

    // Start accepted in the cycle done is high
    run_play(vecs[2]);
    sb.seq_in = 4'b0001; sb.msb_first = 1'b0; sb.period = 8'd0; sb.start = 1'b1;
    step();
    sb.start = 1'b0;
    check("done_restart busy", 32'(sb.busy), 32'd1);
    check("done_restart out", 32'(sb.out), 32'd1);
    check("done_restart index", 32'(sb.index), 32'd0);
    sb.abort = 1'b1;
    step();
    sb.abort = 1'b0;
    check("done_restart abort busy", 32'(sb.busy), 32'd0);

    // Looping with period 0, then abort mid-run
    lp = 4'b0110;
    sb.seq_in = lp; sb.period = 8'd0; sb.msb_first = 1'b0; sb.blank = 1'b0;
    sb.loop = 1'b1; sb.start = 1'b1;
    step();
    sb.start = 1'b0; sb.loop = 1'b0;
    for (int c = 0; c < 14; c++) begin
      check($sformatf("loop c%0d out", c), 32'(sb.out), 32'(lp[c % 4]));
      check($sformatf("loop c%0d index", c), 32'(sb.index), 32'(c % 4));
      check($sformatf("loop c%0d done", c), 32'(sb.done), 32'd0);
      check($sformatf("loop c%0d busy", c), 32'(sb.busy), 32'd1);
      step();
    end
    // c=14 sample: out=1 (lp[2]), index=2
    sb.abort = 1'b1;
    step();
    sb.abort = 1'b0;
    check("abort busy", 32'(sb.busy), 32'd0);
    check("abort out", 32'(sb.out), 32'd0);
    check("abort index", 32'(sb.index), 32'd0);
    check("abort done", 32'(sb.done), 32'd0);
    step();
    check("abort no late done", 32'(sb.done), 32'd0);
    check("abort stays idle", 32'(sb.busy), 32'd0);

    // Start and abort together leave the block idle
    sb.seq_in = 4'b1111; sb.period = 8'd1; sb.start = 1'b1; sb.abort = 1'b1;
    step();
    sb.start = 1'b0; sb.abort = 1'b0;
    check("start_abort busy", 32'(sb.busy), 32'd0);
    check("start_abort out", 32'(sb.out), 32'd0);
    step();
    check("start_abort still idle", 32'(sb.busy), 32'd0);

    // Default-size instance: all ones, period 5
    bb.seq_in = '1; bb.period = 28'd5; bb.start = 1'b1;
    step();
    bb.start = 1'b0;
    max_idx = 0;
    for (int c = 0; c < 108; c++) begin
      check($sformatf("big c%0d out", c), 32'(bb.out), 32'd1);
      check($sformatf("big c%0d index", c), 32'(bb.index), 32'(c / 6));
      check($sformatf("big c%0d busy", c), 32'(bb.busy), 32'd1);
      if (int'(bb.index) > max_idx) max_idx = int'(bb.index);
      step();
    end
    check("big max index", 32'(max_idx), 32'd17);
    check("big done", 32'(bb.done), 32'd1);
    check("big end busy", 32'(bb.busy), 32'd0);

    // Asynchronous reset mid-SHOW
    sb.seq_in = 4'b1011; sb.period = 8'd3; sb.msb_first = 1'b0; sb.blank = 1'b0;
    sb.loop = 1'b0; sb.start = 1'b1;
    step();
    sb.start = 1'b0;
    for (int c = 0; c < 5; c++) step();
    check("pre_rst out", 32'(sb.out), 32'd1);
    check("pre_rst index", 32'(sb.index), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst out", 32'(sb.out), 32'd0);
    check("async_rst index", 32'(sb.index), 32'd0);
    check("async_rst busy", 32'(sb.busy), 32'd0);
    check("async_rst done", 32'(sb.done), 32'd0);
    #1 resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("post_rst c%0d busy", c), 32'(sb.busy), 32'd0);
      check($sformatf("post_rst c%0d out", c), 32'(sb.out), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
